// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter
// Shares one 16x8 program/data RAM between the CPU control sequencer
// (requester 0) and the front-panel loader (requester 1). Each access is a
// fixed three-state transaction: address setup, RAM strobe, data capture.
// The CPU has priority. A starvation counter lets the panel win after
// STARVE_LIMIT consecutive contested CPU grants.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no transaction; arbitrate on any request
// SETUP   | winner's address/data driven to the RAM, strobe low
// STROBE  | RamEn high for one cycle, RamWren = latched write flag
// CAPTURE | RamQ valid; read data captured at end, owner's Done high

module ram_access_arbiter #(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              SysClock,
  input  logic              Clear,
  input  logic              CpuReq,
  input  logic              CpuWrite,
  input  logic [ADDR_W-1:0] CpuAddr,
  input  logic [DATA_W-1:0] CpuWData,
  output logic              CpuGnt,
  output logic              CpuDone,
  input  logic              PnlReq,
  input  logic              PnlWrite,
  input  logic [ADDR_W-1:0] PnlAddr,
  input  logic [DATA_W-1:0] PnlWData,
  output logic              PnlGnt,
  output logic              PnlDone,
  output logic [DATA_W-1:0] RData,
  output logic [ADDR_W-1:0] RamAddr,
  output logic [DATA_W-1:0] RamWData,
  output logic              RamEn,
  output logic              RamWren,
  input  logic [DATA_W-1:0] RamQ,
  output logic              Busy
);

  // Counter is 4 bits wide, enough for the whole 1..15 limit range.
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t     state;
  logic [3:0] starve_cnt;
  logic       lat_write;
  logic       owner_pnl;
  logic       pnl_wins;

  // Arbitration decision; only consumed while in IDLE.
  always_comb begin
    pnl_wins = 1'b0;
    if (PnlReq && (!CpuReq || (starve_cnt == LIMIT)))
      pnl_wins = 1'b1;
  end

  // Transaction sequencer: state, latched request, starvation counter and
  // all registered outputs.
  always_ff @(posedge SysClock) begin
    if (Clear) begin
      state      <= IDLE;
      starve_cnt <= '0;
      lat_write  <= 1'b0;
      owner_pnl  <= 1'b0;
      CpuGnt     <= 1'b0;
      PnlGnt     <= 1'b0;
      CpuDone    <= 1'b0;
      PnlDone    <= 1'b0;
      RamEn      <= 1'b0;
      RamWren    <= 1'b0;
      Busy       <= 1'b0;
      RamAddr    <= '0;
      RamWData   <= '0;
      RData      <= '0;
    end else begin
      case (state)
        IDLE: begin
          CpuDone <= 1'b0;
          PnlDone <= 1'b0;
          RamEn   <= 1'b0;
          RamWren <= 1'b0;
          if (CpuReq || PnlReq) begin
            state     <= SETUP;
            Busy      <= 1'b1;
            owner_pnl <= pnl_wins;
            CpuGnt    <= ~pnl_wins;
            PnlGnt    <= pnl_wins;
            if (pnl_wins) begin
              lat_write  <= PnlWrite;
              RamAddr    <= PnlAddr;
              RamWData   <= PnlWData;
              starve_cnt <= '0;
            end else begin
              lat_write  <= CpuWrite;
              RamAddr    <= CpuAddr;
              RamWData   <= CpuWData;
              // Count only contested CPU wins; an absent panel resets it.
              if (!PnlReq)
                starve_cnt <= '0;
              else if (starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 4'd1;
            end
          end else begin
            starve_cnt <= '0;
          end
        end

        SETUP: begin
          state   <= STROBE;
          RamEn   <= 1'b1;
          RamWren <= lat_write;
        end

        STROBE: begin
          state   <= CAPTURE;
          RamEn   <= 1'b0;
          RamWren <= 1'b0;
          CpuDone <= ~owner_pnl;
          PnlDone <= owner_pnl;
        end

        CAPTURE: begin
          state   <= IDLE;
          CpuDone <= 1'b0;
          PnlDone <= 1'b0;
          CpuGnt  <= 1'b0;
          PnlGnt  <= 1'b0;
          Busy    <= 1'b0;
          if (!lat_write)
            RData <= RamQ;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter
// Directed bench for ram_access_arbiter with a small behavioural RAM.

module tb_ram_access_arbiter;

  logic       clk_sys;
  logic       Clear;
  logic       CpuReq, CpuWrite;
  logic [3:0] CpuAddr;
  logic [7:0] CpuWData;
  logic       CpuGnt, CpuDone;
  logic       PnlReq, PnlWrite;
  logic [3:0] PnlAddr;
  logic [7:0] PnlWData;
  logic       PnlGnt, PnlDone;
  logic [7:0] RData;
  logic [3:0] RamAddr;
  logic [7:0] RamWData;
  logic       RamEn, RamWren;
  logic [7:0] RamQ;
  logic       Busy;

  logic [7:0] mem [16];
  logic [7:0] last_rd;
  int         mcnt;
  int         n_checks;
  int         n_errors;

  ram_access_arbiter #(.ADDR_W(4), .DATA_W(8), .STARVE_LIMIT(3)) dut (
    .SysClock(clk_sys), .Clear(Clear),
    .CpuReq(CpuReq), .CpuWrite(CpuWrite), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
    .CpuGnt(CpuGnt), .CpuDone(CpuDone),
    .PnlReq(PnlReq), .PnlWrite(PnlWrite), .PnlAddr(PnlAddr), .PnlWData(PnlWData),
    .PnlGnt(PnlGnt), .PnlDone(PnlDone),
    .RData(RData), .RamAddr(RamAddr), .RamWData(RamWData),
    .RamEn(RamEn), .RamWren(RamWren), .RamQ(RamQ), .Busy(Busy)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Synchronous RAM: read data appears the cycle after the strobe.
  always @(posedge clk_sys) begin
    if (RamEn) begin
      if (RamWren) mem[RamAddr] <= RamWData;
      else         RamQ <= mem[RamAddr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One uncontested transaction, starting with the DUT idle at this negedge.
  task automatic xact(input bit pnl, input bit wr, input logic [3:0] a,
                      input logic [7:0] d, input logic [7:0] exp_rd, input bit drop);
    CpuReq = !pnl; CpuWrite = wr; CpuAddr = a; CpuWData = d;
    PnlReq = pnl;  PnlWrite = wr; PnlAddr = a; PnlWData = d;
    @(negedge clk_sys);
    chk("setup_cpugnt", CpuGnt, !pnl);
    chk("setup_pnlgnt", PnlGnt, pnl);
    chk("setup_busy", Busy, 1);
    chk("setup_ramen", RamEn, 0);
    chk("setup_addr", RamAddr, a);
    chk("setup_wdata", RamWData, d);
    @(negedge clk_sys);
    chk("strobe_ramen", RamEn, 1);
    chk("strobe_wren", RamWren, wr);
    chk("strobe_addr", RamAddr, a);
    chk("strobe_wdata", RamWData, d);
    chk("strobe_done", CpuDone | PnlDone, 0);
    if (drop) begin CpuReq = 0; PnlReq = 0; end
    @(negedge clk_sys);
    chk("capt_cpudone", CpuDone, !pnl);
    chk("capt_pnldone", PnlDone, pnl);
    chk("capt_ramen", RamEn | RamWren, 0);
    chk("capt_gnt", pnl ? PnlGnt : CpuGnt, 1);
    chk("capt_othergnt", pnl ? CpuGnt : PnlGnt, 0);
    CpuReq = 0; PnlReq = 0;
    @(negedge clk_sys);
    chk("idle_busy", Busy, 0);
    chk("idle_gnt", CpuGnt | PnlGnt, 0);
    chk("idle_done", CpuDone | PnlDone, 0);
    if (!wr) last_rd = exp_rd;
    chk("rdata", RData, last_rd);
  endtask

  // Both requesters held; checks n grants against the starvation model.
  task automatic contest(input int n, input bit keep);
    bit exp_pnl;
    CpuReq = 1; CpuWrite = 0; CpuAddr = 4'h1;
    PnlReq = 1; PnlWrite = 0; PnlAddr = 4'h1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      exp_pnl = (mcnt == 3);
      chk($sformatf("grant%0d_cpu", i), CpuGnt, !exp_pnl);
      chk($sformatf("grant%0d_pnl", i), PnlGnt, exp_pnl);
      mcnt = exp_pnl ? 0 : mcnt + 1;
      @(negedge clk_sys);
      @(negedge clk_sys);
      chk($sformatf("grant%0d_done", i), exp_pnl ? PnlDone : CpuDone, 1);
      @(negedge clk_sys);
      chk($sformatf("grant%0d_idle", i), Busy, 0);
      if (i == n - 1 && !keep) begin
        CpuReq = 0; PnlReq = 0; mcnt = 0;
      end
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0; mcnt = 0; last_rd = 8'h00;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = 8'h91;
    RamQ = 8'h00;
    CpuWrite = 0; CpuAddr = 0; CpuWData = 0;
    PnlWrite = 0; PnlAddr = 0; PnlWData = 0;

    // Reset with both requests high
    Clear = 1; CpuReq = 1; PnlReq = 1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    chk("rst_gnt", {CpuGnt, PnlGnt}, 0);
    chk("rst_done", {CpuDone, PnlDone}, 0);
    chk("rst_ram", {RamEn, RamWren, RamAddr, RamWData}, 0);
    chk("rst_rdata", RData, 0);
    chk("rst_busy", Busy, 0);
    Clear = 0;

    // Starvation pattern CPU x3, PNL, CPU x3, PNL
    contest(8, 0);
    @(negedge clk_sys);
    chk("noreq_busy", Busy, 0);

    xact(0, 1, 4'hA, 8'h3C, 8'h00, 0);
    xact(0, 0, 4'hA, 8'h00, 8'h3C, 0);
    xact(1, 0, 4'h0, 8'h00, 8'h91, 0);
    xact(0, 1, 4'h2, 8'h55, 8'h00, 1);
    xact(0, 0, 4'h2, 8'h00, 8'h55, 0);

    // Clear during STROBE of a panel write
    CpuReq = 0; PnlReq = 1; PnlWrite = 1; PnlAddr = 4'h5; PnlWData = 8'h77;
    @(negedge clk_sys);
    chk("mclr_setup_pnl", PnlGnt, 1);
    @(negedge clk_sys);
    chk("mclr_strobe", RamEn, 1);
    Clear = 1; PnlReq = 0;
    @(negedge clk_sys);
    chk("mclr_ramen", {RamEn, RamWren}, 0);
    chk("mclr_gnt", {CpuGnt, PnlGnt}, 0);
    chk("mclr_busy", Busy, 0);
    chk("mclr_done", {CpuDone, PnlDone}, 0);
    Clear = 0;
    @(negedge clk_sys);
    chk("mclr_nodone", {CpuDone, PnlDone, Busy}, 0);
    last_rd = 8'h00;

    // Clear with the starvation counter part-way up must restart it at 0
    mcnt = 0;
    contest(2, 1);
    @(negedge clk_sys);
    chk("cclr_cpu", CpuGnt, 1);
    @(negedge clk_sys);
    Clear = 1;
    @(negedge clk_sys);
    chk("cclr_busy", Busy, 0);
    chk("cclr_gnt", {CpuGnt, PnlGnt}, 0);
    Clear = 0;
    mcnt = 0;
    contest(4, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
